// File: rtl/change_dispenser_pkg.sv
// Shared coin encodings, coin values and FSM states for the
// vending-machine change path.
package vm_pkg;

   localparam logic [1:0] COIN_NONE    = 2'b00;
   localparam logic [1:0] COIN_NICKEL  = 2'b01;
   localparam logic [1:0] COIN_DIME    = 2'b10;
   localparam logic [1:0] COIN_QUARTER = 2'b11;

   localparam int VAL_NICKEL  = 1;
   localparam int VAL_DIME    = 2;
   localparam int VAL_QUARTER = 5;

   localparam int MAX_CREDIT = 12;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SELECT,
      S_OFFER,
      S_FINISH
   } state_t;

   function automatic int coin_value(input logic [1:0] c);
      int v;
      v = 0;
      case (c)
         COIN_NICKEL:  v = VAL_NICKEL;
         COIN_DIME:    v = VAL_DIME;
         COIN_QUARTER: v = VAL_QUARTER;
         default:      v = 0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Request/eject bundle between the credit controller, the change
// dispenser and the eject solenoid driver.
interface change_dispenser_if #(
   parameter int W = 4
);

   logic         start;
   logic [W-1:0] amount;
   logic         reload;
   logic         eject_ready;
   logic         eject_valid;
   logic [1:0]   eject_coin;
   logic         busy;
   logic         done;
   logic         short_flag;
   logic [W-1:0] remain;

   modport master (
      output start,
      output amount,
      output reload,
      output eject_ready,
      input  eject_valid,
      input  eject_coin,
      input  busy,
      input  done,
      input  short_flag,
      input  remain
   );

   modport slave (
      input  start,
      input  amount,
      input  reload,
      input  eject_ready,
      output eject_valid,
      output eject_coin,
      output busy,
      output done,
      output short_flag,
      output remain
   );

endinterface

// File: rtl/change_dispenser_coin_select.sv
// Greedy coin picker: largest coin that fits the remaining credit
// and is still in stock.
module coin_select #(
   parameter int W       = 4,
   parameter int STOCK_W = 4
) (
   input  logic [W-1:0]       i_remain,
   input  logic [STOCK_W-1:0] i_q_stock,
   input  logic [STOCK_W-1:0] i_d_stock,
   input  logic [STOCK_W-1:0] i_n_stock,
   output logic [1:0]         o_coin,
   output logic               o_found
);

   import vm_pkg::*;

   logic w_q_ok;
   logic w_d_ok;
   logic w_n_ok;

   // Made mutually exclusive so the decoder below is one-hot.
   assign w_q_ok = (i_remain >= W'(VAL_QUARTER))
                && (i_q_stock != '0);
   assign w_d_ok = !w_q_ok
                && (i_remain >= W'(VAL_DIME))
                && (i_d_stock != '0);
   assign w_n_ok = !w_q_ok && !w_d_ok
                && (i_remain >= W'(VAL_NICKEL))
                && (i_n_stock != '0);

   always_comb begin
      o_coin  = COIN_NONE;
      o_found = 1'b0;
      unique case (1'b1)
         w_q_ok: begin
            o_coin  = COIN_QUARTER;
            o_found = 1'b1;
         end
         w_d_ok: begin
            o_coin  = COIN_DIME;
            o_found = 1'b1;
         end
         w_n_ok: begin
            o_coin  = COIN_NICKEL;
            o_found = 1'b1;
         end
         default: begin
            o_coin  = COIN_NONE;
            o_found = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/change_dispenser.sv
// Change-return engine: pays a credit out one coin per eject
// handshake, greedily, against internal per-denomination stock.
module change_dispenser #(
   parameter int W          = 4,
   parameter int MAX_CREDIT = vm_pkg::MAX_CREDIT,
   parameter int STOCK_W    = 4,
   parameter int Q_STOCK    = 8,
   parameter int D_STOCK    = 8,
   parameter int N_STOCK    = 8
) (
   input  logic               i_clk,
   input  logic               i_rst,
   change_dispenser_if.slave  bus
);

   import vm_pkg::*;

   localparam logic [STOCK_W-1:0] L_Q0 = STOCK_W'(Q_STOCK);
   localparam logic [STOCK_W-1:0] L_D0 = STOCK_W'(D_STOCK);
   localparam logic [STOCK_W-1:0] L_N0 = STOCK_W'(N_STOCK);
   localparam logic [W-1:0]       L_MAX = W'(MAX_CREDIT);

   state_t             r_state;
   logic [W-1:0]       r_remain;
   logic [STOCK_W-1:0] r_q;
   logic [STOCK_W-1:0] r_d;
   logic [STOCK_W-1:0] r_n;
   logic               r_valid;
   logic [1:0]         r_coin;
   logic               r_busy;
   logic               r_done;
   logic               r_short;

   state_t             w_state;
   logic [W-1:0]       w_remain;
   logic [STOCK_W-1:0] w_q;
   logic [STOCK_W-1:0] w_d;
   logic [STOCK_W-1:0] w_n;
   logic               w_valid;
   logic [1:0]         w_coin;
   logic               w_busy;
   logic               w_done;
   logic               w_short;

   logic [W-1:0]       w_sat;
   logic [W-1:0]       w_dec;
   logic [1:0]         w_pick;
   logic               w_found;

   coin_select #(
      .W       (W),
      .STOCK_W (STOCK_W)
   ) u_sel (
      .i_remain  (r_remain),
      .i_q_stock (r_q),
      .i_d_stock (r_d),
      .i_n_stock (r_n),
      .o_coin    (w_pick),
      .o_found   (w_found)
   );

   assign w_sat = (bus.amount > L_MAX) ? L_MAX : bus.amount;
   assign w_dec = W'(coin_value(r_coin));

   always_comb begin
      w_state  = r_state;
      w_remain = r_remain;
      w_q      = r_q;
      w_d      = r_d;
      w_n      = r_n;
      w_valid  = r_valid;
      w_coin   = r_coin;
      w_busy   = r_busy;
      w_done   = 1'b0;
      w_short  = r_short;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_remain = w_sat;
               w_busy   = 1'b1;
               w_short  = 1'b0;
               w_state  = S_SELECT;
            end else if (bus.reload) begin
               w_q = L_Q0;
               w_d = L_D0;
               w_n = L_N0;
            end
         end
         S_SELECT: begin
            if (w_found) begin
               w_valid = 1'b1;
               w_coin  = w_pick;
               w_state = S_OFFER;
            end else begin
               w_short = (r_remain != '0);
               w_done  = 1'b1;
               w_state = S_FINISH;
            end
         end
         S_OFFER: begin
            // Coin stays on the bus until the mechanism takes it.
            if (bus.eject_ready) begin
               w_remain = r_remain - w_dec;
               unique case (r_coin)
                  COIN_QUARTER: w_q = r_q - STOCK_W'(1);
                  COIN_DIME:    w_d = r_d - STOCK_W'(1);
                  COIN_NICKEL:  w_n = r_n - STOCK_W'(1);
                  default:      w_n = r_n;
               endcase
               w_valid = 1'b0;
               w_coin  = COIN_NONE;
               w_state = S_SELECT;
            end
         end
         S_FINISH: begin
            w_busy  = 1'b0;
            w_state = S_IDLE;
         end
         default: begin
            w_state = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state  <= S_IDLE;
         r_remain <= '0;
         r_q      <= L_Q0;
         r_d      <= L_D0;
         r_n      <= L_N0;
         r_valid  <= 1'b0;
         r_coin   <= COIN_NONE;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_short  <= 1'b0;
      end else begin
         r_state  <= w_state;
         r_remain <= w_remain;
         r_q      <= w_q;
         r_d      <= w_d;
         r_n      <= w_n;
         r_valid  <= w_valid;
         r_coin   <= w_coin;
         r_busy   <= w_busy;
         r_done   <= w_done;
         r_short  <= w_short;
      end
   end

   assign bus.eject_valid = r_valid;
   assign bus.eject_coin  = r_coin;
   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.short_flag  = r_short;
   assign bus.remain      = r_remain;

endmodule
